// File: rtl/exhaustive_pattern_sweeper.sv
// Exhaustive stimulus + MISR response capture for small single-output DUTs (ascending patterns 0..2^W-1).
// Latency: pattern 0 is applied at the start edge; done rises 2^W*HOLD cycles later.
// Backpressure: none; start while busy is ignored and abort cancels at the next edge.
// Optional response bitmap (full truth table readback) is built when RESP_BITMAP_EN is defined.
module exhaustive_pattern_sweeper #(
  parameter int          W     = 4,
  parameter int          HOLD  = 1,
  parameter int          SIG_W = 16,
  parameter logic [31:0] POLY  = 32'h0000_100B,
  parameter logic [31:0] SEED  = 32'h0000_0000
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic [W-1:0]     pattern,
  output logic             pattern_valid,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [W:0]       ones_count,
  input  logic [W-1:0]     rd_idx,
  output logic             rd_bit
);

  localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [W-1:0]    PAT_LAST  = {W{1'b1}};
  localparam logic [SIG_W-1:0] POLY_L   = POLY[SIG_W-1:0];
  localparam logic [SIG_W-1:0] SEED_L   = SEED[SIG_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_pattern;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [SIG_W-1:0] r_sig;
  logic [W:0]       r_ones;
  logic [HW-1:0]    r_hold;

  logic             w_start_go;
  logic             w_sample;
  logic [SIG_W-1:0] w_sig_next;

  // A sweep may start from IDLE, or from DONE unless abort wins that cycle.
  assign w_start_go = start &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && !abort));

  // Response is sampled on the last cycle of each hold window, never on an abort cycle.
  assign w_sample = (r_state == S_APPLY) && !abort && (r_hold == HOLD_LAST);

  // Shift left, fold the MSB back through the taps, inject the new response at bit 0.
  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY_L : {SIG_W{1'b0}})
                    ^ {{(SIG_W-1){1'b0}}, dut_out};

  // Sweep controller: state, stimulus, hold counter and compacted results.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sig     <= SEED_L;
      r_ones    <= '0;
      r_hold    <= '0;
    end else if (w_start_go) begin
      r_state   <= S_APPLY;
      r_pattern <= '0;
      r_valid   <= 1'b1;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_sig     <= SEED_L;
      r_ones    <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        S_APPLY: begin
          if (abort) begin
            // Partial signature and count are kept for inspection.
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hold  <= '0;
          end else if (w_sample) begin
            r_sig  <= w_sig_next;
            r_ones <= r_ones + {{W{1'b0}}, dut_out};
            r_hold <= '0;
            if (r_pattern != PAT_LAST) begin
              r_pattern <= r_pattern + 1'b1;
            end else begin
              // Last pattern stays on the bus so the DUT input is not disturbed.
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_DONE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pattern       = r_pattern;
  assign pattern_valid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign signature     = r_sig;
  assign ones_count    = r_ones;

`ifdef RESP_BITMAP_EN
  logic [(2**W)-1:0] r_bitmap;

  // Truth-table capture: one bit per pattern, cleared whenever a sweep starts.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_bitmap <= '0;
    end else if (w_start_go) begin
      r_bitmap <= '0;
    end else if (w_sample) begin
      r_bitmap[r_pattern] <= dut_out;
    end
  end

  assign rd_bit = r_bitmap[rd_idx];
`else
  logic w_unused_rd_idx;

  assign w_unused_rd_idx = ^rd_idx;
  assign rd_bit          = 1'b0;
`endif

endmodule

// File: tb/tb_exhaustive_pattern_sweeper.sv
module tb_exhaustive_pattern_sweeper;
  localparam int W = 4;

  logic          CK = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  rd_idx = '0;
  int            mode = 0;

  logic [W-1:0]  pat1, pat2;
  logic          val1, val2, busy1, busy2, done1, done2, rdb1, rdb2, dout1, dout2;
  logic [15:0]   sig1, sig2;
  logic [W:0]    ones1, ones2;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [W-1:0]  exp_q[$];

  // Reference DUT behaviours: 0 tie-low, 1 tie-high, 2 pattern[0], 3 4-input AND.
  function automatic logic model_out(input int m, input logic [W-1:0] p);
    case (m)
      1:       return 1'b1;
      2:       return p[0];
      3:       return &p;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {15'b0, b};
  endfunction

  always_comb dout1 = model_out(mode, pat1);
  always_comb dout2 = model_out(mode, pat2);

  initial forever #5 CK = ~CK;

  exhaustive_pattern_sweeper #(.W(W), .HOLD(1)) u_h1 (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .dut_out(dout1),
    .pattern(pat1), .pattern_valid(val1), .busy(busy1), .done(done1),
    .signature(sig1), .ones_count(ones1), .rd_idx(rd_idx), .rd_bit(rdb1)
  );

  exhaustive_pattern_sweeper #(.W(W), .HOLD(2)) u_h2 (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .dut_out(dout2),
    .pattern(pat2), .pattern_valid(val2), .busy(busy2), .done(done2),
    .signature(sig2), .ones_count(ones2), .rd_idx(rd_idx), .rd_bit(rdb2)
  );

  // Full sweep on the instance with hold h; the queue holds one expected pattern per cycle.
  task automatic run_sweep(input int h, input bit pre_abort, input string tag,
                           output logic [15:0] got_sig);
    logic [15:0]  e_sig;
    logic [W:0]   e_ones;
    logic [W-1:0] e_pat;
    logic         b;
    int           step;
    exp_q.delete();
    e_sig  = 16'h0000;
    e_ones = '0;
    for (int p = 0; p < 16; p++) begin
      b      = model_out(mode, W'(p));
      e_sig  = misr_step(e_sig, b);
      e_ones = e_ones + (W+1)'(b);
      for (int c = 0; c < h; c++) exp_q.push_back(W'(p));
    end
    if (pre_abort) begin
      @(negedge CK); abort = 1'b1;
      @(negedge CK); abort = 1'b0;
    end
    @(negedge CK); start = 1'b1;
    @(negedge CK); start = 1'b0;
    step = 0;
    while (exp_q.size() > 0) begin
      e_pat = exp_q.pop_front();
      n_checks++;
      if ((h == 1 ? pat1 : pat2) !== e_pat || (h == 1 ? val1 : val2) !== 1'b1 ||
          (h == 1 ? busy1 : busy2) !== 1'b1 || (h == 1 ? done1 : done2) !== 1'b0)
        $display("FAIL %s step%0d: pattern=%0d valid=%b busy=%b done=%b, want pattern=%0d valid=1 busy=1 done=0",
                 tag, step, (h == 1 ? pat1 : pat2), (h == 1 ? val1 : val2),
                 (h == 1 ? busy1 : busy2), (h == 1 ? done1 : done2), e_pat);
      else n_pass++;
      @(negedge CK);
      step++;
    end
    n_checks++;
    if ((h == 1 ? done1 : done2) !== 1'b1 || (h == 1 ? busy1 : busy2) !== 1'b0 ||
        (h == 1 ? val1 : val2) !== 1'b0 || (h == 1 ? pat1 : pat2) !== 4'hF)
      $display("FAIL %s end: done=%b busy=%b valid=%b pattern=%0d, want 1 0 0 15", tag,
               (h == 1 ? done1 : done2), (h == 1 ? busy1 : busy2),
               (h == 1 ? val1 : val2), (h == 1 ? pat1 : pat2));
    else n_pass++;
    got_sig = (h == 1) ? sig1 : sig2;
    n_checks++;
    if (got_sig !== e_sig) $display("FAIL %s signature: got %h want %h", tag, got_sig, e_sig);
    else n_pass++;
    n_checks++;
    if ((h == 1 ? ones1 : ones2) !== e_ones)
      $display("FAIL %s ones_count: got %0d want %0d", tag, (h == 1 ? ones1 : ones2), e_ones);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge CK);
    n_checks++;
    if (pat1 !== 4'h0 || val1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL reset_ctl: pattern=%0d valid=%b busy=%b done=%b, want 0 0 0 0", pat1, val1, busy1, done1);
    else n_pass++;
    n_checks++;
    if (sig1 !== 16'h0000 || ones1 !== 5'd0 || rdb1 !== 1'b0)
      $display("FAIL reset_res: sig=%h ones=%0d rd_bit=%b, want 0000 0 0", sig1, ones1, rdb1);
    else n_pass++;
    n_checks++;
    if (pat2 !== 4'h0 || val2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0 || sig2 !== 16'h0000 || ones2 !== 5'd0)
      $display("FAIL reset_h2: pattern=%0d valid=%b busy=%b done=%b sig=%h ones=%0d, want all 0",
               pat2, val2, busy2, done2, sig2, ones2);
    else n_pass++;
    @(negedge CK); reset = 1'b1;
  endtask

  task automatic test_hold1_zero();
    logic [15:0] s;
    mode = 0;
    run_sweep(1, 1'b0, "hold1_zero", s);
  endtask

  task automatic test_hold2_alt();
    logic [15:0] s;
    mode = 2;
    run_sweep(2, 1'b1, "hold2_alt", s);
  endtask

  task automatic test_all_ones_restart();
    logic [15:0] s_a, s_b;
    mode = 1;
    run_sweep(1, 1'b1, "all_ones", s_a);
    run_sweep(1, 1'b0, "restart_done", s_b);
    n_checks++;
    if (s_b !== s_a) $display("FAIL restart_same_sig: got %h want %h", s_b, s_a);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [15:0] e_sig;
    logic [15:0] s;
    int t;
    mode = 1;
    @(negedge CK); abort = 1'b1;
    @(negedge CK); abort = 1'b0; start = 1'b1;
    @(negedge CK); start = 1'b0;
    t = 0;
    while (pat1 !== 4'd5 && t < 50) begin
      @(negedge CK);
      t++;
    end
    n_checks++;
    if (t >= 50) $display("FAIL abort_reach5: pattern=%0d after %0d cycles, want 5", pat1, t);
    else n_pass++;
    abort = 1'b1;
    @(negedge CK); abort = 1'b0;
    e_sig = 16'h0000;
    for (int i = 0; i < 5; i++) e_sig = misr_step(e_sig, 1'b1);
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || val1 !== 1'b0)
      $display("FAIL abort_idle: busy=%b done=%b valid=%b, want 0 0 0", busy1, done1, val1);
    else n_pass++;
    n_checks++;
    if (ones1 !== 5'd5 || sig1 !== e_sig)
      $display("FAIL abort_partial: ones=%0d sig=%h, want 5 %h", ones1, sig1, e_sig);
    else n_pass++;
    run_sweep(1, 1'b0, "after_abort", s);
    // From DONE, abort must win over a simultaneous start.
    abort = 1'b1; start = 1'b1;
    @(negedge CK); abort = 1'b0; start = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || val1 !== 1'b0)
      $display("FAIL abort_over_start: busy=%b done=%b valid=%b, want 0 0 0", busy1, done1, val1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    mode = 1;
    @(negedge CK); start = 1'b1;
    @(negedge CK); start = 1'b0;
    repeat (4) @(negedge CK);
    @(posedge CK);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (pat1 !== 4'h0 || val1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0 || sig1 !== 16'h0000 || ones1 !== 5'd0)
      $display("FAIL midreset_h1: pattern=%0d valid=%b busy=%b done=%b sig=%h ones=%0d, want all 0",
               pat1, val1, busy1, done1, sig1, ones1);
    else n_pass++;
    n_checks++;
    if (pat2 !== 4'h0 || val2 !== 1'b0 || busy2 !== 1'b0 || sig2 !== 16'h0000 || ones2 !== 5'd0)
      $display("FAIL midreset_h2: pattern=%0d valid=%b busy=%b sig=%h ones=%0d, want all 0",
               pat2, val2, busy2, sig2, ones2);
    else n_pass++;
    @(negedge CK); start = 1'b1;
    repeat (2) @(negedge CK);
    n_checks++;
    if (busy1 !== 1'b0 || val1 !== 1'b0)
      $display("FAIL start_in_reset: busy=%b valid=%b, want 0 0", busy1, val1);
    else n_pass++;
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge CK);
    n_checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || pat1 !== 4'h0)
      $display("FAIL idle_after_reset: busy=%b done=%b pattern=%0d, want 0 0 0", busy1, done1, pat1);
    else n_pass++;
  endtask

  task automatic test_bitmap();
    logic [15:0] s;
    mode = 3;
    run_sweep(1, 1'b1, "and_sweep", s);
`ifdef RESP_BITMAP_EN
    for (int i = 0; i < 16; i++) begin
      rd_idx = W'(i);
      #1;
      n_checks++;
      if (rdb1 !== (i == 15)) $display("FAIL bitmap idx%0d: got %b want %b", i, rdb1, (i == 15));
      else n_pass++;
    end
    @(negedge CK); mode = 0; start = 1'b1;
    @(negedge CK); start = 1'b0;
    rd_idx = 4'hF;
    #1;
    n_checks++;
    if (rdb1 !== 1'b0) $display("FAIL bitmap_cleared: got %b want 0", rdb1);
    else n_pass++;
`else
    for (int i = 0; i < 16; i++) begin
      rd_idx = W'(i);
      #1;
      n_checks++;
      if (rdb1 !== 1'b0 || rdb2 !== 1'b0)
        $display("FAIL rd_bit_tied idx%0d: got %b/%b want 0/0", i, rdb1, rdb2);
      else n_pass++;
    end
`endif
  endtask

  initial begin
    test_reset();
    test_hold1_zero();
    test_hold2_alt();
    test_all_ones_restart();
    test_abort();
    test_reset_mid();
    test_bitmap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exhaustive_pattern_sweeper.md
Name: exhaustive_pattern_sweeper

Overview:
- Upstream stimulus and downstream response-capture stage for the small single-output benchmark circuits (4-input, 1-output DUTs) used in trojan detection.
- Drives every input pattern 0..2^W-1 to the DUT in ascending binary order and holds each one for HOLD cycles.
- Samples the DUT's single output at the end of each hold window and compacts all responses into a MISR signature plus a ones count.
- Lets a golden DUT and a suspect DUT be compared in hardware rather than through a file dump.

Parameters:
- W, 4, DUT input width; number of patterns = 2^W (W in 1..8).
- HOLD, 1, cycles each pattern is held before sampling (>=1).
- SIG_W, 16, MISR width.
- POLY, 16'h100B, MISR feedback taps (x^16+x^12+x^3+x+1); low SIG_W bits used.
- SEED, 0, MISR value loaded on start.

Ports:
- CK  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep.
- abort  input  1  synchronous sweep cancel.
- dut_out  input  1  DUT single-bit response.
- pattern  output  W  stimulus to DUT; pattern[W-1] is MSB and maps to DUT input N[0].
- pattern_valid  output  1  pattern is being applied.
- busy  output  1  sweep in progress.
- done  output  1  sweep completed; level.
- signature  output  SIG_W  MISR result.
- ones_count  output  W+1  number of patterns with dut_out=1.
- rd_idx  input  W  bitmap read index (macro only).
- rd_bit  output  1  stored response for rd_idx (macro only).

Behaviour:
- Reset (reset=0, async) clears all state. Resulting outputs:
  - state IDLE, pattern=0, pattern_valid=0, busy=0, done=0.
  - signature=SEED, ones_count=0, hold counter=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE -> APPLY when start=1 at edge k. At that edge:
  - pattern<=0, pattern_valid<=1, busy<=1, done<=0.
  - signature<=SEED, ones_count<=0, hold counter<=0.
- APPLY:
  - Hold counter counts 0..HOLD-1.
  - At the edge where the counter equals HOLD-1, dut_out is sampled, then:
    - signature <= {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0..,dut_out}.
    - ones_count += dut_out.
    - counter <= 0.
    - If pattern != 2^W-1: pattern increments.
    - Else: go to DONE with busy<=0, pattern_valid<=0, done<=1, and pattern holds its last value.
- Timing: done rises at edge k + 2^W*HOLD. Each pattern is stable for exactly HOLD cycles.
- DONE: done and results hold. start=1 re-enters APPLY exactly as from IDLE, clearing done the same edge.
- start while busy: ignored.
- abort=1 in APPLY or DONE:
  - Next state IDLE; busy, pattern_valid and done all go to 0.
  - signature and ones_count hold their partial values.
  - abort has priority over start and over sample completion in the same cycle.
- ones_count width W+1 so that the all-ones case reaching 2^W fits without wrap.
- reset deasserted mid-sweep: the block stays in IDLE and waits for a new start.

Optional Feature:
- RESP_BITMAP_EN defined:
  - A 2^W-bit register records dut_out at index=pattern on every sample, and is cleared on start.
  - rd_bit = bitmap[rd_idx], combinational.
  - Holds the full truth table for bit-level diffing against the golden DUT.
- Not defined:
  - rd_idx is unused; rd_bit is tied to 0.
  - No bitmap storage is built.

Test Plan:
- W=4, HOLD=1, SEED=0, dut_out tied 0, start pulse -> pattern steps 0..15 one per cycle; done rises 16 cycles after start; signature=0; ones_count=0.
- W=4, HOLD=2, dut_out=pattern[0] -> each pattern held 2 cycles; done rises 32 cycles after start; ones_count=8; signature matches bench MISR model fed 0,1,0,1,...
- dut_out tied 1, HOLD=1 -> ones_count=16, no wrap; signature matches model; a second start in DONE yields an identical signature.
- abort asserted at pattern 5 -> IDLE next edge; busy=0, done=0; ones_count retains the partial count; a start pulse after abort sweeps from 0 again.
- Async reset asserted mid-APPLY, off-edge -> all outputs immediately at reset values; start ignored until reset=1.
- RESP_BITMAP_EN, DUT = 4-input AND -> rd_bit=1 only for rd_idx=15; the bitmap is cleared on the next start.
